// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: drives March steps onto the SRAM, compares read data
// against the expected background, and reports sticky pass/fail status.
module bist_response_analyzer #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned PATTERN_WIDTH = 2,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [ADDR_WIDTH+PATTERN_WIDTH:0]   counter_out,
  input  logic                                cout,
  input  logic [DATA_WIDTH-1:0]               sram_dout,
  output logic                                sram_cs,
  output logic                                sram_we,
  output logic [ADDR_WIDTH-1:0]               sram_addr,
  output logic [DATA_WIDTH-1:0]               sram_din,
  output logic                                fail,
  output logic [ADDR_WIDTH-1:0]               first_fail_addr,
  output logic [PATTERN_WIDTH-1:0]            first_fail_pattern,
  output logic [7:0]                          fail_count,
  output logic                                done,
  output logic                                pass
);

  localparam int unsigned STEP_W = ADDR_WIDTH + PATTERN_WIDTH + 1;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LAT_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // One outstanding read: what it must return and where it came from.
  typedef struct packed {
    logic                     valid;
    logic [DATA_WIDTH-1:0]    exp;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [PATTERN_WIDTH-1:0] decode;
  } rd_entry_t;

  // Expected word for a decode value; the checkerboard phase flips with addr[0].
  function automatic logic [DATA_WIDTH-1:0] background(
    input logic [PATTERN_WIDTH-1:0] dec,
    input logic                     addr_lsb
  );
    logic [DATA_WIDTH-1:0] chk_bg;
    chk_bg = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      chk_bg[i] = ((i % 2) == 0) ? ~addr_lsb : addr_lsb;
    end
    case (dec)
      PATTERN_WIDTH'(1): background = '1;
      PATTERN_WIDTH'(2): background = chk_bg;
      PATTERN_WIDTH'(3): background = ~chk_bg;
      default:           background = '0;
    endcase
  endfunction

  state_e                   state_q, state_d;
  logic [LAT_W-1:0]         drain_cnt_q, drain_cnt_d;
  rd_entry_t                pipe_q [READ_LATENCY];
  rd_entry_t                issue_c;
  rd_entry_t                head_c;
  logic                     mismatch_c;
  logic                     access_c;

  logic [ADDR_WIDTH-1:0]    step_addr_c;
  logic                     step_we_c;
  logic [PATTERN_WIDTH-1:0] step_dec_c;
  logic [DATA_WIDTH-1:0]    step_bg_c;

  logic                     fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]    ffa_q, ffa_d;
  logic [PATTERN_WIDTH-1:0] ffp_q, ffp_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;

  // Split the counter step into its fields and derive the background word.
  assign step_addr_c = counter_out[ADDR_WIDTH-1:0];
  assign step_we_c   = counter_out[ADDR_WIDTH];
  assign step_dec_c  = counter_out[STEP_W-1:ADDR_WIDTH+1];
  assign step_bg_c   = background(step_dec_c, step_addr_c[0]);

  // An access happens only in RUN, with enable high and the counter not finished.
  assign access_c  = (state_q == S_RUN) & en & ~cout;

  assign sram_cs   = access_c;
  assign sram_we   = access_c & step_we_c;
  assign sram_addr = step_addr_c;
  assign sram_din  = step_bg_c;

  // FSM state and drain counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state logic; DRAIN lasts exactly READ_LATENCY cycles.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (en && cout) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == LAT_W'(READ_LATENCY - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + LAT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Entry launched into the read pipeline this cycle.
  always_comb begin
    issue_c        = '0;
    issue_c.valid  = access_c & ~step_we_c;
    issue_c.exp    = step_bg_c;
    issue_c.addr   = step_addr_c;
    issue_c.decode = step_dec_c;
  end

  // Read pipeline: the last stage lines up with valid sram_dout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= issue_c;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign head_c     = pipe_q[READ_LATENCY-1];
  assign mismatch_c = head_c.valid & (sram_dout != head_c.exp);

  // Result update: sticky fail, first-failure capture, saturating count.
  always_comb begin
    fail_d = fail_q;
    ffa_d  = ffa_q;
    ffp_d  = ffp_q;
    cnt_d  = cnt_q;
    if (mismatch_c) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        ffa_d = head_c.addr;
        ffp_d = head_c.decode;
      end
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    done_d = (state_d == S_DONE);
    pass_d = done_d & ~fail_d;
  end

  // Result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_q <= 1'b0;
      ffa_q  <= '0;
      ffp_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      fail_q <= fail_d;
      ffa_q  <= ffa_d;
      ffp_q  <= ffp_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign fail               = fail_q;
  assign first_fail_addr    = ffa_q;
  assign first_fail_pattern = ffp_q;
  assign fail_count         = cnt_q;
  assign done               = done_q;
  assign pass               = pass_q;

endmodule
